// File: rtl/map_overlay_buffered_pkg.sv
// Shared types and constants for the buffered map overlay:
// fixed-point player coordinates, overlay colours and fetcher states.
package map_overlay_buffered_pkg;

    // Player coordinates: 8 integer bits above 8 fraction bits.
    localparam int FIX_W    = 16;
    localparam int FIX_FRAC = 8;
    typedef logic [FIX_W-1:0] fix_t;

    // First hblank column; the row fetch for the next line starts here.
    localparam int H_VIEW_DEFAULT = 640;

    // BBGGRR colours.
    localparam logic [5:0] RGB_PLAYER = 6'b00_11_11;
    localparam logic [5:0] RGB_PCELL  = 6'b00_01_00;
    localparam logic [5:0] RGB_GRID   = 6'b01_00_00;
    localparam logic [5:0] RGB_WALL   = 6'b11_00_00;
    localparam logic [5:0] RGB_BLACK  = 6'b00_00_00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } fetch_state_t;

    // Fraction field of a fixed-point coordinate.
    function automatic logic [FIX_FRAC-1:0] fix_frac(input fix_t v);
        return v[FIX_FRAC-1:0];
    endfunction

endpackage

// File: rtl/map_overlay_buffered_fetcher.sv
// map_row_fetcher: reads one map row per hblank over a req/ack port into
// a double-buffered row cache; swaps at line start or flags a miss.
// Ports: clk, reset, hpos, vpos, overlay_en; ROM req/col/row/ack/val;
//        o_fetch_miss (sticky); active_row (row shown on the current line).
module map_row_fetcher
    import map_overlay_buffered_pkg::*;
#(
    parameter int H_VIEW          = H_VIEW_DEFAULT,
    parameter int MAP_WIDTH_BITS  = 4,
    parameter int MAP_HEIGHT_BITS = 4,
    parameter int MAP_SCALE       = 3,
    parameter int OVL_Y           = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [9:0]                       hpos,
    input  logic [9:0]                       vpos,
    input  logic                             overlay_en,
    output logic                             o_map_req,
    output logic [MAP_WIDTH_BITS-1:0]        o_map_col,
    output logic [MAP_HEIGHT_BITS-1:0]       o_map_row,
    input  logic                             i_map_ack,
    input  logic                             i_map_val,
    output logic                             o_fetch_miss,
    output logic [(1<<MAP_WIDTH_BITS)-1:0]   active_row
);

    localparam int MW = 1 << MAP_WIDTH_BITS;
    localparam int MH = 1 << MAP_HEIGHT_BITS;

    localparam logic [9:0] H_VIEW10 = 10'(H_VIEW);
    localparam logic [9:0] OY10     = 10'(OVL_Y);
    localparam logic [9:0] ROWS_PX  = 10'(MH << MAP_SCALE);
    localparam logic [MAP_WIDTH_BITS-1:0] LAST_COL =
        MAP_WIDTH_BITS'(MW - 1);

    fetch_state_t state;

    logic [MW-1:0] buf_a;
    logic [MW-1:0] buf_b;
    logic          sel_b;

    logic [9:0]  vp1;
    logic [10:0] vdiff;
    logic [9:0]  vn;
    logic        trigger;
    logic        line_start;
    logic [MAP_HEIGHT_BITS-1:0] trig_row;

    // Row for the next line, relative to the overlay top; the borrow bit
    // of vdiff means the next line is above the overlay.
    assign vp1      = vpos + 10'd1;
    assign vdiff    = {1'b0, vp1} - {1'b0, OY10};
    assign vn       = vdiff[9:0];
    assign trig_row = vn[MAP_SCALE +: MAP_HEIGHT_BITS];

    assign trigger = overlay_en && (hpos == H_VIEW10)
                  && !vdiff[10] && (vn < ROWS_PX);

    assign line_start = (hpos == 10'd0);

    assign active_row = sel_b ? buf_b : buf_a;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            o_map_req    <= 1'b0;
            o_map_col    <= '0;
            o_map_row    <= '0;
            buf_a        <= '0;
            buf_b        <= '0;
            sel_b        <= 1'b0;
            o_fetch_miss <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        state     <= ST_FETCH;
                        o_map_req <= 1'b1;
                        o_map_col <= '0;
                        o_map_row <= trig_row;
                    end
                end
                ST_FETCH: begin
                    if (line_start) begin
                        // Too late: keep showing the previous row.
                        o_fetch_miss <= 1'b1;
                        o_map_req    <= 1'b0;
                        state        <= ST_IDLE;
                    end else if (i_map_ack) begin
                        if (sel_b) begin
                            buf_a[o_map_col] <= i_map_val;
                        end else begin
                            buf_b[o_map_col] <= i_map_val;
                        end
                        if (!overlay_en) begin
                            o_map_req <= 1'b0;
                            state     <= ST_IDLE;
                        end else if (o_map_col == LAST_COL) begin
                            o_map_req <= 1'b0;
                            state     <= ST_DONE;
                        end else begin
                            o_map_col <= o_map_col + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (line_start) begin
                        sel_b <= ~sel_b;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    o_map_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/map_overlay_buffered.sv
// Top-down map overlay: geometry, gridlines, player marker and walls
// from a row cache filled during hblank by map_row_fetcher.
// Ports: clk, reset, hpos, vpos, playerX/Y, overlay_en; ROM req/ack port;
//        in_map_overlay, map_rgb (BBGGRR), o_fetch_miss.
module map_overlay_buffered
    import map_overlay_buffered_pkg::*;
#(
    parameter int H_VIEW          = H_VIEW_DEFAULT,
    parameter int MAP_WIDTH_BITS  = 4,
    parameter int MAP_HEIGHT_BITS = 4,
    parameter int MAP_SCALE       = 3,
    parameter int OVL_X           = 0,
    parameter int OVL_Y           = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [9:0]                 hpos,
    input  logic [9:0]                 vpos,
    input  fix_t                       playerX,
    input  fix_t                       playerY,
    input  logic                       overlay_en,
    output logic                       o_map_req,
    output logic [MAP_WIDTH_BITS-1:0]  o_map_col,
    output logic [MAP_HEIGHT_BITS-1:0] o_map_row,
    input  logic                       i_map_ack,
    input  logic                       i_map_val,
    output logic                       in_map_overlay,
    output logic [5:0]                 map_rgb,
    output logic                       o_fetch_miss
);

    localparam int MW = 1 << MAP_WIDTH_BITS;
    localparam int MH = 1 << MAP_HEIGHT_BITS;
    localparam int CW = 10 - MAP_SCALE;

    // One extra pixel/line closes the grid on the right and bottom.
    localparam logic [9:0] OW   = 10'((MW << MAP_SCALE) + 1);
    localparam logic [9:0] OH   = 10'((MH << MAP_SCALE) + 1);
    localparam logic [9:0] OX10 = 10'(OVL_X);
    localparam logic [9:0] OY10 = 10'(OVL_Y);

    logic [MW-1:0] active_row;

    map_row_fetcher #(
        .H_VIEW          (H_VIEW),
        .MAP_WIDTH_BITS  (MAP_WIDTH_BITS),
        .MAP_HEIGHT_BITS (MAP_HEIGHT_BITS),
        .MAP_SCALE       (MAP_SCALE),
        .OVL_Y           (OVL_Y)
    ) u_fetch (
        .clk          (clk),
        .reset        (reset),
        .hpos         (hpos),
        .vpos         (vpos),
        .overlay_en   (overlay_en),
        .o_map_req    (o_map_req),
        .o_map_col    (o_map_col),
        .o_map_row    (o_map_row),
        .i_map_ack    (i_map_ack),
        .i_map_val    (i_map_val),
        .o_fetch_miss (o_fetch_miss),
        .active_row   (active_row)
    );

    logic [10:0] hdiff;
    logic [10:0] vdiff;
    logic [9:0]  hx;
    logic [9:0]  vy;

    // Borrow bit set means the beam is left of / above the overlay.
    assign hdiff = {1'b0, hpos} - {1'b0, OX10};
    assign vdiff = {1'b0, vpos} - {1'b0, OY10};
    assign hx    = hdiff[9:0];
    assign vy    = vdiff[9:0];

    assign in_map_overlay = overlay_en
                         && !hdiff[10] && (hx < OW)
                         && !vdiff[10] && (vy < OH);

    // Full-width cell numbers, so the closing gridline column/row never
    // aliases onto cell 0.
    logic [CW-1:0]        cell_x;
    logic [CW-1:0]        cell_y;
    logic [MAP_SCALE-1:0] sub_x;
    logic [MAP_SCALE-1:0] sub_y;

    assign cell_x = hx[9:MAP_SCALE];
    assign cell_y = vy[9:MAP_SCALE];
    assign sub_x  = hx[MAP_SCALE-1:0];
    assign sub_y  = vy[MAP_SCALE-1:0];

    logic [MAP_WIDTH_BITS-1:0]  pl_cx;
    logic [MAP_HEIGHT_BITS-1:0] pl_cy;
    logic [MAP_SCALE-1:0]       pl_sx;
    logic [MAP_SCALE-1:0]       pl_sy;
    logic [FIX_FRAC-1:0]        frac_x;
    logic [FIX_FRAC-1:0]        frac_y;

    assign pl_cx  = playerX[FIX_FRAC +: MAP_WIDTH_BITS];
    assign pl_cy  = playerY[FIX_FRAC +: MAP_HEIGHT_BITS];
    assign frac_x = fix_frac(playerX);
    assign frac_y = fix_frac(playerY);
    assign pl_sx  = frac_x[FIX_FRAC-1 -: MAP_SCALE];
    assign pl_sy  = frac_y[FIX_FRAC-1 -: MAP_SCALE];

    logic unused_player;
    assign unused_player = ^{playerX, playerY};

    logic pl_cell;
    logic pl_pix;
    logic grid;
    logic wall;

    assign pl_cell = (cell_x == CW'(pl_cx)) && (cell_y == CW'(pl_cy));
    assign pl_pix  = pl_cell && (sub_x == pl_sx) && (sub_y == pl_sy);
    assign grid    = (sub_x == '0) || (sub_y == '0);
    assign wall    = active_row[hx[MAP_SCALE +: MAP_WIDTH_BITS]];

    always_comb begin
        map_rgb = RGB_BLACK;
        if (in_map_overlay) begin
            if (pl_pix) begin
                map_rgb = RGB_PLAYER;
            end else if (pl_cell) begin
                map_rgb = RGB_PCELL;
            end else if (grid) begin
                map_rgb = RGB_GRID;
            end else if (wall) begin
                map_rgb = RGB_WALL;
            end
        end
    end

endmodule
